// File: rtl/game_pkg.sv
// Shared raster constants and arbiter state encoding
// for the game video pipeline.
package game_pkg;

    localparam logic [9:0] H_MAX = 10'd799;
    localparam logic [9:0] V_MAX = 10'd520;
    localparam logic [9:0] H_VIS = 10'd640;
    localparam logic [9:0] V_VIS = 10'd480;

    localparam logic [1:0] LIVES_INIT = 2'd3;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        RESOLVE = 2'd1,
        CLEAR   = 2'd2
    } state_t;

endpackage

// File: rtl/frame_tick.sv
// Combinational one-clk tick on the last pixel strobe
// of a frame.
module frame_tick
    import game_pkg::*;
(
    input  logic       pix_en,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       tick
);

    assign tick = pix_en && (x == H_MAX) && (y == V_MAX);

endmodule

// File: rtl/collision_ctrl.sv
// Per-frame collision arbiter: latches overlaps during the
// visible raster and resolves them once at frame end.
module collision_ctrl
    import game_pkg::*;
#(
    parameter int INVULN_FRAMES = 120,
    parameter int SCORE_MAX     = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        pause,
    input  logic        game_start_on,
    input  logic        p_on,
    input  logic        pb_on,
    input  logic        e_r_on,
    input  logic        e_active,
    input  logic        eb_on,
    output logic        hit_r_enemy,
    output logic        hit_player,
    output logic [1:0]  lives,
    output logic        invuln,
    output logic [13:0] score,
    output logic        game_over
);

    localparam int CW = $clog2(INVULN_FRAMES + 1);

    state_t        state;
    state_t        state_nx;
    logic          frame_end;
    logic          flag_e;
    logic          flag_p;
    logic [CW-1:0] cnt;
    logic          visible;
    logic          sample;
    logic          do_res;
    logic          hit_e_nx;
    logic          hit_p_nx;
    logic          flush;

    frame_tick u_tick (
        .pix_en (pix_en),
        .x      (x),
        .y      (y),
        .tick   (frame_end)
    );

    assign visible = (x < H_VIS) && (y < V_VIS);
    assign sample  = (state == SCAN) && pix_en && !pause
                     && !game_over && visible;
    assign do_res  = (state == RESOLVE) && !pause && !game_over;
    assign hit_e_nx = do_res && flag_e;
    assign hit_p_nx = do_res && flag_p && (cnt == '0);
    assign invuln   = (cnt != '0);

    // Pause drops any half-collected frame so it cannot leak into the next
    assign flush = (state == CLEAR) || game_over
                   || (pause && (frame_end || state != SCAN));

    always_comb begin
        state_nx = state;
        unique case (state)
            SCAN:    if (frame_end && !pause) state_nx = RESOLVE;
            RESOLVE: state_nx = CLEAR;
            CLEAR:   state_nx = SCAN;
            default: state_nx = SCAN;
        endcase
        if (pause) state_nx = SCAN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SCAN;
            flag_e      <= 1'b0;
            flag_p      <= 1'b0;
            cnt         <= '0;
            hit_r_enemy <= 1'b0;
            hit_player  <= 1'b0;
            lives       <= LIVES_INIT;
            score       <= '0;
            game_over   <= 1'b0;
        end else if (game_start_on) begin
            state       <= SCAN;
            flag_e      <= 1'b0;
            flag_p      <= 1'b0;
            cnt         <= '0;
            hit_r_enemy <= 1'b0;
            hit_player  <= 1'b0;
            lives       <= LIVES_INIT;
            score       <= '0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_nx;
            hit_r_enemy <= hit_e_nx;
            hit_player  <= hit_p_nx;
            if (hit_e_nx && score != 14'(SCORE_MAX))
                score <= score + 14'd1;
            if (hit_p_nx) begin
                if (lives != 2'd0) lives <= lives - 2'd1;
                if (lives <= 2'd1) game_over <= 1'b1;
                cnt <= CW'(INVULN_FRAMES);
            end else if (do_res && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (flush) begin
                flag_e <= 1'b0;
                flag_p <= 1'b0;
            end else if (sample) begin
                if (pb_on && e_r_on && e_active) flag_e <= 1'b1;
                if (p_on && (e_r_on || eb_on))   flag_p <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_collision_ctrl.sv
// Directed scoreboard bench for collision_ctrl using
// compressed frames (sparse pixel strobes plus frame end).
module tb_collision_ctrl;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pause;
    logic        game_start_on;
    logic        p_on;
    logic        pb_on;
    logic        e_r_on;
    logic        e_active;
    logic        eb_on;
    logic        hit_r_enemy;
    logic        hit_player;
    logic [1:0]  lives;
    logic        invuln;
    logic [13:0] score;
    logic        game_over;

    collision_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .pix_en        (pix_en),
        .x             (x),
        .y             (y),
        .pause         (pause),
        .game_start_on (game_start_on),
        .p_on          (p_on),
        .pb_on         (pb_on),
        .e_r_on        (e_r_on),
        .e_active      (e_active),
        .eb_on         (eb_on),
        .hit_r_enemy   (hit_r_enemy),
        .hit_player    (hit_player),
        .lives         (lives),
        .invuln        (invuln),
        .score         (score),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int he;
        int hp;
        int lv;
        int sc;
        int inv;
        int go;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int   m_fe;
    int   m_fp;
    int   m_lives;
    int   m_score;
    int   m_cnt;
    int   m_go;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_fe = 0;
        m_fp = 0;
        m_lives = 3;
        m_score = 0;
        m_cnt = 0;
        m_go = 0;
        sb.delete();
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_he"}, int'(hit_r_enemy), 0);
        chk({tag, "_hp"}, int'(hit_player), 0);
        chk({tag, "_lives"}, int'(lives), m_lives);
        chk({tag, "_score"}, int'(score), m_score);
        chk({tag, "_inv"}, int'(invuln), int'(m_cnt != 0));
        chk({tag, "_go"}, int'(game_over), m_go);
    endtask

    task automatic pix(input logic [9:0] px, input logic [9:0] py,
                       input bit p, input bit pb, input bit er,
                       input bit ea, input bit eb, input int n);
        for (int i = 0; i < n; i++) begin
            x = px + 10'(i);
            y = py;
            pix_en = 1'b1;
            p_on = p;
            pb_on = pb;
            e_r_on = er;
            e_active = ea;
            eb_on = eb;
            if (!pause && m_go == 0 && x < 10'd640 && y < 10'd480) begin
                if (pb && er && ea) m_fe = 1;
                if (p && (er || eb)) m_fp = 1;
            end
            cyc();
            pix_en = 1'b0;
            {p_on, pb_on, e_r_on, e_active, eb_on} = '0;
            cyc();
        end
    endtask

    task automatic frame_end(input string tag);
        exp_t e;
        exp_t g;
        e.he = 0;
        e.hp = 0;
        if (!pause && m_go == 0) begin
            if (m_fe != 0) begin
                e.he = 1;
                if (m_score != 9999) m_score++;
            end
            if (m_fp != 0 && m_cnt == 0) begin
                e.hp = 1;
                if (m_lives > 0) m_lives--;
                if (m_lives == 0) m_go = 1;
                m_cnt = 120;
            end else if (m_cnt > 0) begin
                m_cnt--;
            end
        end
        m_fe = 0;
        m_fp = 0;
        e.lv = m_lives;
        e.sc = m_score;
        e.inv = int'(m_cnt != 0);
        e.go = m_go;
        sb.push_back(e);
        x = H_MAX;
        y = V_MAX;
        pix_en = 1'b1;
        cyc();
        pix_en = 1'b0;
        x = 10'd0;
        y = 10'd0;
        chk({tag, "_early_he"}, int'(hit_r_enemy), 0);
        chk({tag, "_early_hp"}, int'(hit_player), 0);
        cyc();
        g = sb.pop_front();
        chk({tag, "_he"}, int'(hit_r_enemy), g.he);
        chk({tag, "_hp"}, int'(hit_player), g.hp);
        chk({tag, "_lives"}, int'(lives), g.lv);
        chk({tag, "_score"}, int'(score), g.sc);
        chk({tag, "_inv"}, int'(invuln), g.inv);
        chk({tag, "_go"}, int'(game_over), g.go);
        cyc();
        chk({tag, "_late_he"}, int'(hit_r_enemy), 0);
        chk({tag, "_late_hp"}, int'(hit_player), 0);
        cyc();
    endtask

    task automatic start_game();
        game_start_on = 1'b1;
        cyc();
        game_start_on = 1'b0;
        model_reset();
        chk_state("start");
    endtask

    initial begin
        rst = 1'b0;
        pix_en = 1'b0;
        x = '0;
        y = '0;
        pause = 1'b0;
        game_start_on = 1'b0;
        {p_on, pb_on, e_r_on, e_active, eb_on} = '0;
        model_reset();
        cyc();
        cyc();
        chk_state("reset");
        rst = 1'b1;
        cyc();

        pix(10'd100, 10'd100, 0, 1, 1, 1, 0, 4);
        frame_end("ehit");
        frame_end("ehit_next");

        pix(10'd100, 10'd100, 0, 1, 1, 0, 0, 4);
        frame_end("e_inactive");

        pix(10'd700, 10'd100, 0, 1, 1, 1, 0, 2);
        frame_end("out_x");
        pix(10'd100, 10'd500, 0, 1, 1, 1, 0, 2);
        frame_end("out_y");
        pix(10'd639, 10'd479, 0, 1, 1, 1, 0, 1);
        frame_end("edge_vis");

        pix(10'd200, 10'd50, 0, 1, 1, 1, 0, 2);
        pause = 1'b1;
        frame_end("pause");
        pause = 1'b0;
        frame_end("after_pause");

        pix(10'd300, 10'd200, 1, 0, 0, 0, 1, 2);
        frame_end("phit0");
        for (int f = 1; f <= 120; f++) begin
            pix(10'd300, 10'd200, 1, 0, 0, 0, 1, 1);
            frame_end("pinv");
        end
        pix(10'd300, 10'd200, 1, 0, 0, 0, 1, 1);
        frame_end("phit121");

        start_game();
        for (int k = 0; k < 3; k++) begin
            pix(10'd300, 10'd200, 1, 0, 1, 0, 0, 1);
            frame_end("gohit");
            for (int f = 0; f < 130 && m_cnt != 0; f++)
                frame_end("gowait");
        end
        pix(10'd100, 10'd100, 1, 1, 1, 1, 1, 3);
        frame_end("gofrozen");
        start_game();

        for (int k = 0; k < 5; k++) begin
            pix(10'd50, 10'd60, 0, 1, 1, 1, 0, 1);
            frame_end("pre_rst");
        end
        pix(10'd300, 10'd200, 1, 0, 0, 0, 1, 1);
        frame_end("pre_rst_p");
        x = 10'd20;
        y = 10'd30;
        pix_en = 1'b1;
        pb_on = 1'b1;
        e_r_on = 1'b1;
        e_active = 1'b1;
        rst = 1'b0;
        model_reset();
        #1;
        chk_state("rst_async");
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_state("rst_hold");
        end
        pix_en = 1'b0;
        {p_on, pb_on, e_r_on, e_active, eb_on} = '0;
        rst = 1'b1;
        cyc();
        chk_state("rst_done");
        pix(10'd100, 10'd100, 0, 1, 1, 1, 0, 1);
        frame_end("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
